// File: rtl/n64_response_tx.sv
// n64_response_tx
//   Serialises a response frame onto the N64 single-wire data line.
//   Bit encoding (1 unit = CLKS_PER_US cycles):
//     '0' = 3 units driven low, then 1 unit released.
//     '1' = 1 unit driven low, then 3 units released.
//   The frame is followed by a stop bit: 2 units driven low, then released.
//   Bytes go out byte 0 first, MSB first. Byte 0 sits in the top byte of tx_data.
//
// Ports
//   sample_clk : single clock, all logic on the rising edge
//   reset      : asynchronous, active-low reset
//   enable     : low keeps the block idle and aborts any frame in progress
//   start      : one-cycle request to transmit a frame
//   tx_len     : number of bytes to send, valid range 1..MAX_BYTES
//   tx_data    : payload, byte 0 in the most-significant byte
//   data_oe    : 1 = open-drain pad pulls the line low, 0 = line released
//   busy       : high while a frame is on the line
//   done       : one-cycle pulse after a frame completes normally
//   err        : one-cycle pulse when a start is rejected for a bad tx_len
module n64_response_tx #(
  parameter int CLKS_PER_US = 4,
  parameter int MAX_BYTES   = 4
) (
  input  logic                   sample_clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   start,
  input  logic [2:0]             tx_len,
  input  logic [8*MAX_BYTES-1:0] tx_data,
  output logic                   data_oe,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int DATA_W = 8 * MAX_BYTES;
  localparam int CNT_W  = $clog2(3 * CLKS_PER_US);
  localparam int BYTE_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  // Terminal counts for each phase length (count runs 0 .. len-1).
  localparam logic [CNT_W-1:0] END_1U = CNT_W'(CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0] END_2U = CNT_W'(2 * CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0] END_3U = CNT_W'(3 * CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BYTE_W-1:0] BYTE_ONE = BYTE_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BIT_LOW  = 2'd1,
    BIT_HIGH = 2'd2,
    STOP_LOW = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic [2:0]          len_q, len_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                data_oe_q, data_oe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                len_ok;
  logic                cur_bit;
  logic [CNT_W-1:0]    phase_end;
  logic                expired;
  logic                last_bit;

  assign len_ok   = (tx_len != 3'd0) && (32'(tx_len) <= 32'(MAX_BYTES));
  assign cur_bit  = shift_q[DATA_W-1];
  assign expired  = (cnt_q == phase_end);
  assign last_bit = (bit_q == 3'd7) && (32'(byte_q) + 32'd1 == 32'(len_q));

  // The current bit stays at the top of the shift register for the whole
  // bit time, so the phase length can be taken straight from it.
  always_comb begin
    phase_end = END_1U;
    case (state_q)
      BIT_LOW:  phase_end = cur_bit ? END_1U : END_3U;
      BIT_HIGH: phase_end = cur_bit ? END_3U : END_1U;
      STOP_LOW: phase_end = END_2U;
      default:  phase_end = END_1U;
    endcase
  end

  // State register (outputs are registered alongside so they never glitch).
  always_ff @(posedge sample_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      len_q     <= '0;
      shift_q   <= '0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      len_q     <= len_d;
      shift_q   <= shift_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    len_d   = len_q;
    shift_d = shift_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (start && len_ok) begin
            state_d = BIT_LOW;
            shift_d = tx_data;
            len_d   = tx_len;
            bit_d   = '0;
            byte_d  = '0;
          end
        end
        BIT_LOW: begin
          if (expired) begin
            state_d = BIT_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        BIT_HIGH: begin
          if (expired) begin
            cnt_d   = '0;
            state_d = last_bit ? STOP_LOW : BIT_LOW;
            shift_d = shift_q << 1;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              byte_d = byte_q + BYTE_ONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STOP_LOW: begin
          if (expired) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with it
  // in the cycle after each edge.
  always_comb begin
    data_oe_d = (state_d == BIT_LOW) || (state_d == STOP_LOW);
    busy_d    = (state_d != IDLE);
    done_d    = enable && (state_q == STOP_LOW) && expired;
    err_d     = enable && (state_q == IDLE) && start && !len_ok;
  end

  assign data_oe = data_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_n64_response_tx.sv
module tb_n64_response_tx;

  localparam int U = 4;

  logic        sample_clk = 1'b0;
  logic        reset      = 1'b1;
  logic        enable     = 1'b0;
  logic        start      = 1'b0;
  logic [2:0]  tx_len     = 3'd0;
  logic [31:0] tx_data    = 32'h0;
  logic        data_oe;
  logic        busy;
  logic        done;
  logic        err;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 sample_clk = ~sample_clk;

  n64_response_tx #(
    .CLKS_PER_US(U),
    .MAX_BYTES  (4)
  ) dut (
    .sample_clk(sample_clk),
    .reset     (reset),
    .enable    (enable),
    .start     (start),
    .tx_len    (tx_len),
    .tx_data   (tx_data),
    .data_oe   (data_oe),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Vector compared everywhere: {busy, data_oe, done, err}
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed {busy,oe,done,err}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sample_clk);
    #1;
  endtask

  // Expected line drive in cycle k (1-based) after the accepting edge.
  function automatic logic exp_oe(input int len, input logic [31:0] d, input int k);
    int idx;
    int bitn;
    int off;
    idx  = k - 1;
    bitn = idx / (4 * U);
    off  = idx % (4 * U);
    if (bitn < len * 8) begin
      if (d[31 - bitn]) return (off < U);
      else              return (off < 3 * U);
    end
    return ((idx - len * 32 * U) < 2 * U);
  endfunction

  task automatic launch(input logic [2:0] len, input logic [31:0] d);
    start   = 1'b1;
    tx_len  = len;
    tx_data = d;
    tick();
    start   = 1'b0;
  endtask

  // Checks frame cycles from..to; leaves the bench in cycle 'to'.
  task automatic expect_frame(input string name, input int len, input logic [31:0] d,
                              input int from, input int to);
    for (int k = from; k <= to; k++) begin
      chk($sformatf("%s k=%0d", name, k), {busy, data_oe, done, err},
          {1'b1, exp_oe(len, d, k), 2'b00});
      if (k < to) tick();
    end
  endtask

  initial begin
    // Reset behaviour
    #2 reset = 1'b0;
    #1 chk("reset_async", {busy, data_oe, done, err}, 4'b0000);
    tick();
    tick();
    chk("reset_hold", {busy, data_oe, done, err}, 4'b0000);

    // Release and start on the very first edge afterwards; all-zero byte
    reset  = 1'b1;
    enable = 1'b1;
    launch(3'd1, 32'h0000_0000);
    expect_frame("byte00", 1, 32'h0000_0000, 1, 136);
    tick();
    chk("byte00_done", {busy, data_oe, done, err}, 4'b0010);

    // Start issued in the done cycle; byte 0x81
    launch(3'd1, 32'h8100_0000);
    expect_frame("byte81", 1, 32'h8100_0000, 1, 136);
    tick();
    chk("byte81_done", {busy, data_oe, done, err}, 4'b0010);
    tick();
    chk("byte81_idle", {busy, data_oe, done, err}, 4'b0000);

    // Four bytes, with a start at cycle 100 that must be ignored
    launch(3'd4, 32'h0500_0201);
    expect_frame("len4", 4, 32'h0500_0201, 1, 100);
    start   = 1'b1;
    tx_len  = 3'd1;
    tx_data = 32'hFFFF_FFFF;
    tick();
    start   = 1'b0;
    expect_frame("len4", 4, 32'h0500_0201, 101, 520);
    tick();
    chk("len4_done", {busy, data_oe, done, err}, 4'b0010);
    tick();
    chk("len4_single_done", {busy, data_oe, done, err}, 4'b0000);

    // Enable dropped at cycle 50
    launch(3'd1, 32'hA500_0000);
    expect_frame("en_frame", 1, 32'hA500_0000, 1, 50);
    enable = 1'b0;
    tick();
    chk("en_abort", {busy, data_oe, done, err}, 4'b0000);
    tick();
    chk("en_no_done", {busy, data_oe, done, err}, 4'b0000);
    launch(3'd1, 32'hFF00_0000);
    chk("start_while_disabled", {busy, data_oe, done, err}, 4'b0000);
    enable = 1'b1;
    tick();
    chk("reenable_idle", {busy, data_oe, done, err}, 4'b0000);
    launch(3'd1, 32'h3C00_0000);
    expect_frame("after_en", 1, 32'h3C00_0000, 1, 136);
    tick();
    chk("after_en_done", {busy, data_oe, done, err}, 4'b0010);
    tick();

    // Reset pulsed at cycle 30 of a frame
    launch(3'd2, 32'hC35A_0000);
    expect_frame("rst_frame", 2, 32'hC35A_0000, 1, 30);
    #2 reset = 1'b0;
    #1 chk("rst_mid_async", {busy, data_oe, done, err}, 4'b0000);
    tick();
    chk("rst_mid_hold", {busy, data_oe, done, err}, 4'b0000);
    reset = 1'b1;
    launch(3'd2, 32'h6E91_0000);
    expect_frame("post_rst", 2, 32'h6E91_0000, 1, 264);
    tick();
    chk("post_rst_done", {busy, data_oe, done, err}, 4'b0010);

    // Reset while the line is actively pulled low
    launch(3'd1, 32'hFF00_0000);
    expect_frame("rst_low", 1, 32'hFF00_0000, 1, 1);
    #2 reset = 1'b0;
    #1 chk("rst_oe_async", {busy, data_oe, done, err}, 4'b0000);
    tick();
    reset = 1'b1;
    tick();
    chk("rst_oe_no_done", {busy, data_oe, done, err}, 4'b0000);

    // Invalid lengths
    launch(3'd0, 32'h1234_5678);
    chk("err_len0", {busy, data_oe, done, err}, 4'b0001);
    tick();
    chk("err_len0_once", {busy, data_oe, done, err}, 4'b0000);
    launch(3'd5, 32'hFFFF_FFFF);
    chk("err_len5", {busy, data_oe, done, err}, 4'b0001);
    tick();
    chk("err_len5_once", {busy, data_oe, done, err}, 4'b0000);
    launch(3'd7, 32'h0000_0000);
    chk("err_len7", {busy, data_oe, done, err}, 4'b0001);
    tick();
    chk("err_len7_once", {busy, data_oe, done, err}, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/n64_response_tx.md
N64_RESPONSE_TX -- requirements
Module: n64_response_tx

Interface
REQ-001 The block SHALL have the parameter CLKS_PER_US, default 4, giving the number of sample_clk cycles per 1 us protocol unit (4 MHz clock).
REQ-002 The block SHALL have the parameter MAX_BYTES, default 4, giving the maximum number of response bytes per frame.
REQ-003 The block SHALL have the port sample_clk, input, 1 bit: the single clock, with all logic on the rising edge.
REQ-004 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have the port enable, input, 1 bit: when low, the block stays idle and any frame in progress is aborted.
REQ-006 The block SHALL have the port start, input, 1 bit: a single-cycle request to transmit a frame.
REQ-007 The block SHALL have the port tx_len, input, 3 bits: the number of bytes to send, with valid values 1..MAX_BYTES.
REQ-008 The block SHALL have the port tx_data, input, 8*MAX_BYTES bits: the payload, where byte 0 is in the most-significant byte.
REQ-009 The block SHALL have the port data_oe, output, 1 bit: when 1, the external open-drain pad pulls the N64 data line low; when 0, the line is released (high).
REQ-010 The block SHALL have the port busy, output, 1 bit: high while a frame is on the line.
REQ-011 The block SHALL have the port done, output, 1 bit: a one-cycle pulse when a frame completes normally.
REQ-012 The block SHALL have the port err, output, 1 bit: a one-cycle pulse when a start is rejected because tx_len is invalid.

Function
REQ-013 Bit encoding SHALL follow the N64 response timing, with each bit lasting 4 us:
- '0' = data_oe=1 for 3*CLKS_PER_US cycles, then data_oe=0 for 1*CLKS_PER_US cycles.
- '1' = data_oe=1 for 1*CLKS_PER_US cycles, then data_oe=0 for 3*CLKS_PER_US cycles.
REQ-014 Bytes SHALL be sent in order byte 0 to byte tx_len-1, MSB first within each byte.
REQ-015 After the last data bit, the stop bit SHALL be data_oe=1 for 2*CLKS_PER_US cycles, then data_oe=0.
REQ-016 The state machine SHALL have the states IDLE, BIT_LOW, BIT_HIGH and STOP_LOW, with these transitions:
- IDLE to BIT_LOW on an accepted start.
- BIT_LOW to BIT_HIGH when the low phase count expires.
- BIT_HIGH to BIT_LOW when the high phase count expires and bits remain.
- BIT_HIGH to STOP_LOW when the high phase count expires after the last bit.
- STOP_LOW to IDLE when the 2 us count expires.
REQ-017 A start SHALL be accepted only in IDLE with enable=1 and 1<=tx_len<=MAX_BYTES; tx_data and tx_len SHALL be latched in that cycle.
REQ-018 Latency: for a start accepted at edge N, data_oe and busy SHALL go to 1 in the cycle after edge N.
REQ-019 All outputs SHALL be registered and glitch-free.
REQ-020 busy SHALL stay high for exactly tx_len*8*4*CLKS_PER_US + 2*CLKS_PER_US cycles.
REQ-021 done SHALL pulse in the first cycle after busy falls, coincident with data_oe returning to 0.
REQ-022 A start received while busy SHALL be ignored: no latch, no err, no effect on the current frame.
REQ-023 A start with tx_len=0 or tx_len>MAX_BYTES while in IDLE SHALL produce an err pulse in the next cycle, with busy and data_oe staying 0.
REQ-024 Deasserting enable mid-frame SHALL, at the next edge, force data_oe=0, busy=0 and the state to IDLE, with no done pulse.
REQ-025 If start and enable=0 occur in the same cycle, the start SHALL be ignored.
REQ-026 A start in the same cycle as a done pulse SHALL be accepted, because the block is already in IDLE.
REQ-027 The bit counter, byte counter and unit counter SHALL be sized for MAX_BYTES*8 bits and for CLKS_PER_US, with no wrap-around within a frame.

Reset
REQ-028 While reset=0, the block SHALL asynchronously force data_oe=0, busy=0, done=0, err=0, the state to IDLE and all counters and the shift register to 0.
REQ-029 Reset asserted mid-frame SHALL release the line immediately (without waiting for a clock edge), and no done pulse SHALL follow.
REQ-030 After reset is released, the block SHALL accept a start on the first rising edge.

Verification
REQ-031 Scenario: tx_len=1, tx_data[31:24]=0x00 -> eight repetitions of (12 cycles data_oe=1, 4 cycles data_oe=0), then 8 cycles data_oe=1, then done on the 137th cycle after start.
REQ-032 Scenario: tx_len=1, byte 0x81 -> bit pattern 4/12, 12/4 (x6), 4/12, then the stop bit; busy is high for exactly 136 cycles.
REQ-033 Scenario: tx_len=4, tx_data=0x0500_0201 -> 32 bits MSB first, busy for 520 cycles, one done pulse; a second start issued at cycle 100 is ignored.
REQ-034 Scenario: enable dropped at cycle 50 of a frame -> data_oe=0 and busy=0 at the next edge, no done; a fresh start is then accepted.
REQ-035 Scenario: reset pulsed low at cycle 30 of a frame -> data_oe drops without a clock edge; the next start after release produces a full, correct frame.
REQ-036 Scenario: start with tx_len=0, then with tx_len=5 -> one err pulse each, with busy and data_oe staying 0.
